// File: rtl/alu_issue.sv
// alu_issue: single-issue front end for an external combinational ALU.
// Each accepted instruction walks IDLE -> EXEC -> WB -> IDLE. Operands are read
// from an 8-entry register file at the transfer edge and presented to the ALU
// during EXEC. The ALU response is captured at the end of EXEC, and the result
// is written back at the end of WB.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   instr              [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [8:0] imm9
//   instr_valid/ready  instruction handshake (ready only in IDLE)
//   alu_reg_A/B        ALU operands (zero outside EXEC)
//   alu_cop            ALU operation code (zero outside EXEC)
//   alu_result/ovf     combinational ALU response
//   wb_valid/rd/data   one-cycle write-back notification (WB state)
//   ovf_flag           overflow flag from ADD/SUB; clear_ovf clears it
//   illegal            one-cycle pulse in WB for an undefined opcode
//
// Configuration macro: ALU_ISSUE_STICKY_OVF_EN makes ovf_flag sticky
// (set by ADD/SUB overflow, cleared only by clear_ovf or reset).
module alu_issue #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] alu_reg_A,
    output logic [DATA_WIDTH-1:0] alu_reg_B,
    output logic [3:0]            alu_cop,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_ovf,
    output logic                  wb_valid,
    output logic [2:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ovf_flag,
    input  logic                  clear_ovf,
    output logic                  illegal
);

    localparam logic [3:0] OP_CLR   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_MOV   = 4'h3;
    localparam logic [3:0] OP_CMPEQ = 4'h4;
    localparam logic [3:0] OP_LDI   = 4'h7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e                state_q,    state_d;
    logic [15:0]           instr_q,    instr_d;
    logic [DATA_WIDTH-1:0] rf_q [8];
    logic [DATA_WIDTH-1:0] rf_d [8];
    logic [DATA_WIDTH-1:0] alu_a_q,    alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q,    alu_b_d;
    logic [3:0]            alu_cop_q,  alu_cop_d;
    logic                  ovf_cap_q,  ovf_cap_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [2:0]            wb_rd_q,    wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q,  wb_data_d;
    logic                  illegal_q,  illegal_d;
    logic                  ovf_flag_q, ovf_flag_d;

    logic [3:0]            ex_op;
    logic [2:0]            ex_rd;
    logic [DATA_WIDTH-1:0] ex_imm;

    assign ex_op  = instr_q[15:12];
    assign ex_rd  = instr_q[11:9];
    assign ex_imm = DATA_WIDTH'(instr_q[8:0]);

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_CMPEQ) || (op == OP_LDI);
    endfunction

    function automatic logic [3:0] op_cop(input logic [3:0] op);
        case (op)
            OP_CLR:   return 4'b0000;
            OP_ADD:   return 4'b0001;
            OP_SUB:   return 4'b0010;
            OP_MOV:   return 4'b0011;
            OP_CMPEQ: return 4'b0100;
            default:  return 4'b0000;   // LDI and illegal opcodes do not use the ALU
        endcase
    endfunction

    // Ready is held low while reset is asserted.
    assign instr_ready = (state_q == S_IDLE) && !reset;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        rf_d       = rf_q;
        // ALU drive defaults to zero; only the transfer edge loads it, so it
        // is non-zero exactly during EXEC.
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_cop_d  = '0;
        ovf_cap_d  = ovf_cap_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        ovf_flag_d = clear_ovf ? 1'b0 : ovf_flag_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    state_d = S_EXEC;
                    instr_d = instr;
                    // Any earlier write-back has already landed, so these
                    // reads are the values the register file holds in EXEC.
                    alu_a_d   = rf_q[instr[8:6]];
                    alu_b_d   = rf_q[instr[5:3]];
                    alu_cop_d = op_cop(instr[15:12]);
                end
            end
            S_EXEC: begin
                state_d   = S_WB;
                ovf_cap_d = alu_ovf;
                if (op_legal(ex_op)) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = ex_rd;
                    wb_data_d  = (ex_op == OP_LDI) ? ex_imm : alu_result;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                if (wb_valid_q) begin
                    rf_d[wb_rd_q] = wb_data_q;
                end
                // Overflow update overrides a simultaneous clear_ovf.
                if ((ex_op == OP_ADD) || (ex_op == OP_SUB)) begin
`ifdef ALU_ISSUE_STICKY_OVF_EN
                    if (ovf_cap_q) begin
                        ovf_flag_d = 1'b1;
                    end
`else
                    ovf_flag_d = ovf_cap_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            rf_q       <= '{default: '0};
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cop_q  <= '0;
            ovf_cap_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            rf_q       <= rf_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cop_q  <= alu_cop_d;
            ovf_cap_q  <= ovf_cap_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    assign alu_reg_A = alu_a_q;
    assign alu_reg_B = alu_b_q;
    assign alu_cop   = alu_cop_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign illegal   = illegal_q;
    assign ovf_flag  = ovf_flag_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed, table-driven bench for alu_issue with a small
// behavioural ALU (carry/borrow as overflow) attached to the ALU port.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_issue;

    localparam int W = 16;

`ifdef ALU_ISSUE_STICKY_OVF_EN
    localparam logic OVF_AFTER_ADD = 1'b1;
`else
    localparam logic OVF_AFTER_ADD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [W-1:0]  alu_reg_A;
    logic [W-1:0]  alu_reg_B;
    logic [3:0]    alu_cop;
    logic [W-1:0]  alu_result;
    logic          alu_ovf;
    logic          wb_valid;
    logic [2:0]    wb_rd;
    logic [W-1:0]  wb_data;
    logic          ovf_flag;
    logic          clear_ovf;
    logic          illegal;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    alu_issue #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_reg_A   (alu_reg_A),
        .alu_reg_B   (alu_reg_B),
        .alu_cop     (alu_cop),
        .alu_result  (alu_result),
        .alu_ovf     (alu_ovf),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ovf_flag    (ovf_flag),
        .clear_ovf   (clear_ovf),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Reference ALU: overflow is unsigned carry (ADD) or borrow (SUB).
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (alu_cop)
            4'b0001: {alu_ovf, alu_result} = {1'b0, alu_reg_A} + {1'b0, alu_reg_B};
            4'b0010: begin
                alu_result = alu_reg_A - alu_reg_B;
                alu_ovf    = (alu_reg_A < alu_reg_B);
            end
            4'b0011: alu_result = alu_reg_B;
            4'b0100: alu_result = (alu_reg_A == alu_reg_B) ? 16'h0001 : 16'h0000;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'h7, rd, imm};
    endfunction

    typedef struct {
        logic [15:0] ins;
        logic        chk_ab;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  cop;
        logic        wb;
        logic [2:0]  rd;
        logic [15:0] data;
        logic        ill;
        logic        ovf;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] ins, input logic chk_ab,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] cop, input logic wb,
                                input logic [2:0] rd, input logic [15:0] data,
                                input logic ill, input logic ovf);
        vec_t v;
        v.ins = ins; v.chk_ab = chk_ab; v.a = a; v.b = b; v.cop = cop;
        v.wb = wb; v.rd = rd; v.data = data; v.ill = ill; v.ovf = ovf;
        return v;
    endfunction

    typedef struct {
        logic        timeout;
        logic [3:0]  ex_cop;
        logic [15:0] ex_a;
        logic [15:0] ex_b;
        logic        ex_wb;
        logic        wb;
        logic [2:0]  rd;
        logic [15:0] data;
        logic        ill;
        logic [35:0] wb_alu;
        logic        post_ready;
        logic        post_wb;
        logic        post_ill;
        logic        ovf;
    } obs_t;

    // Issue one instruction from an IDLE falling edge and observe EXEC, WB and
    // the following IDLE cycle; returns at the falling edge of that IDLE cycle.
    task automatic issue(input logic [15:0] ins, output obs_t o);
        int unsigned n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        o.timeout   = !instr_ready;
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = '0;
        o.ex_cop = alu_cop;
        o.ex_a   = alu_reg_A;
        o.ex_b   = alu_reg_B;
        o.ex_wb  = wb_valid;
        @(negedge clk);
        o.wb     = wb_valid;
        o.rd     = wb_rd;
        o.data   = wb_data;
        o.ill    = illegal;
        o.wb_alu = {alu_reg_A, alu_reg_B, alu_cop};
        @(negedge clk);
        o.post_ready = instr_ready;
        o.post_wb    = wb_valid;
        o.post_ill   = illegal;
        o.ovf        = ovf_flag;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t        vecs [21];
    obs_t        o;
    logic [15:0] bb_ins [4];
    logic [15:0] bb_exp [4];
    int unsigned idx, xfers, wbs;
    logic        xfer_prev;

    initial begin
        // r1=0FF, r2=001, r3=r1+r2, then r1=0 for the borrow case.
        vecs[0]  = mk(ldi(3'd1, 9'h0FF),         1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 3'd1, 16'h00FF, 1'b0, 1'b0);
        vecs[1]  = mk(ldi(3'd2, 9'h001),         1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 3'd2, 16'h0001, 1'b0, 1'b0);
        vecs[2]  = mk(enc(4'h1, 3'd3, 3'd1, 3'd2), 1'b1, 16'h00FF, 16'h0001, 4'h1, 1'b1, 3'd3, 16'h0100, 1'b0, 1'b0);
        vecs[3]  = mk(ldi(3'd1, 9'h000),         1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 3'd1, 16'h0000, 1'b0, 1'b0);
        vecs[4]  = mk(enc(4'h2, 3'd4, 3'd1, 3'd2), 1'b1, 16'h0000, 16'h0001, 4'h2, 1'b1, 3'd4, 16'hFFFF, 1'b0, 1'b1);
        vecs[5]  = mk(enc(4'h1, 3'd5, 3'd2, 3'd2), 1'b1, 16'h0001, 16'h0001, 4'h1, 1'b1, 3'd5, 16'h0002, 1'b0, OVF_AFTER_ADD);
        vecs[6]  = mk(enc(4'h4, 3'd6, 3'd1, 3'd1), 1'b1, 16'h0000, 16'h0000, 4'h4, 1'b1, 3'd6, 16'h0001, 1'b0, OVF_AFTER_ADD);
        vecs[7]  = mk(enc(4'h4, 3'd6, 3'd1, 3'd2), 1'b1, 16'h0000, 16'h0001, 4'h4, 1'b1, 3'd6, 16'h0000, 1'b0, OVF_AFTER_ADD);
        vecs[8]  = mk(enc(4'h3, 3'd7, 3'd0, 3'd4), 1'b1, 16'h0000, 16'hFFFF, 4'h3, 1'b1, 3'd7, 16'hFFFF, 1'b0, OVF_AFTER_ADD);
        vecs[9]  = mk(enc(4'h0, 3'd0, 3'd3, 3'd3), 1'b1, 16'h0100, 16'h0100, 4'h0, 1'b1, 3'd0, 16'h0000, 1'b0, OVF_AFTER_ADD);
        vecs[10] = mk(enc(4'hA, 3'd3, 3'd1, 3'd2), 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b1, OVF_AFTER_ADD);
        vecs[11] = mk(enc(4'h1, 3'd5, 3'd4, 3'd2), 1'b1, 16'hFFFF, 16'h0001, 4'h1, 1'b1, 3'd5, 16'h0000, 1'b0, 1'b1);
        vecs[12] = mk(enc(4'hF, 3'd2, 3'd2, 3'd2), 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1);
        // Read every register back with MOV rN,rN,rN.
        vecs[13] = mk(enc(4'h3, 3'd1, 3'd1, 3'd1), 1'b1, 16'h0000, 16'h0000, 4'h3, 1'b1, 3'd1, 16'h0000, 1'b0, 1'b1);
        vecs[14] = mk(enc(4'h3, 3'd2, 3'd2, 3'd2), 1'b1, 16'h0001, 16'h0001, 4'h3, 1'b1, 3'd2, 16'h0001, 1'b0, 1'b1);
        vecs[15] = mk(enc(4'h3, 3'd3, 3'd3, 3'd3), 1'b1, 16'h0100, 16'h0100, 4'h3, 1'b1, 3'd3, 16'h0100, 1'b0, 1'b1);
        vecs[16] = mk(enc(4'h3, 3'd4, 3'd4, 3'd4), 1'b1, 16'hFFFF, 16'hFFFF, 4'h3, 1'b1, 3'd4, 16'hFFFF, 1'b0, 1'b1);
        vecs[17] = mk(enc(4'h3, 3'd5, 3'd5, 3'd5), 1'b1, 16'h0000, 16'h0000, 4'h3, 1'b1, 3'd5, 16'h0000, 1'b0, 1'b1);
        vecs[18] = mk(enc(4'h3, 3'd6, 3'd6, 3'd6), 1'b1, 16'h0000, 16'h0000, 4'h3, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b1);
        vecs[19] = mk(enc(4'h3, 3'd7, 3'd7, 3'd7), 1'b1, 16'hFFFF, 16'hFFFF, 4'h3, 1'b1, 3'd7, 16'hFFFF, 1'b0, 1'b1);
        vecs[20] = mk(enc(4'h3, 3'd0, 3'd0, 3'd0), 1'b1, 16'h0000, 16'h0000, 4'h3, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b1);

        bb_ins[0] = ldi(3'd1, 9'h011); bb_exp[0] = 16'h0011;
        bb_ins[1] = ldi(3'd2, 9'h022); bb_exp[1] = 16'h0022;
        bb_ins[2] = ldi(3'd3, 9'h133); bb_exp[2] = 16'h0133;
        bb_ins[3] = ldi(3'd4, 9'h1FF); bb_exp[3] = 16'h01FF;

        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        clear_ovf   = 1'b0;

        // Reset state (sampled while reset is still high)
        @(negedge clk);
        instr_valid = 1'b1;
        @(negedge clk);
        chk("rst_ready",    32'(instr_ready), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid),    32'h0);
        chk("rst_illegal",  32'(illegal),     32'h0);
        chk("rst_ovf",      32'(ovf_flag),    32'h0);
        chk("rst_wb_rd",    32'(wb_rd),       32'h0);
        chk("rst_wb_data",  32'(wb_data),     32'h0);
        chk("rst_alu",      32'({alu_reg_A, alu_reg_B, alu_cop} != 36'h0), 32'h0);
        instr_valid = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(instr_ready), 32'h1);

        // Directed vector table
        for (int i = 0; i < 21; i++) begin
            issue(vecs[i].ins, o);
            chk($sformatf("v%0d_ready_wait", i), 32'(o.timeout), 32'h0);
            chk($sformatf("v%0d_exec_cop", i),   32'(o.ex_cop),  32'(vecs[i].cop));
            if (vecs[i].chk_ab) begin
                chk($sformatf("v%0d_exec_a", i), 32'(o.ex_a), 32'(vecs[i].a));
                chk($sformatf("v%0d_exec_b", i), 32'(o.ex_b), 32'(vecs[i].b));
            end
            chk($sformatf("v%0d_exec_wb_low", i), 32'(o.ex_wb), 32'h0);
            chk($sformatf("v%0d_wb_valid", i),    32'(o.wb),    32'(vecs[i].wb));
            if (vecs[i].wb) begin
                chk($sformatf("v%0d_wb_rd", i),   32'(o.rd),   32'(vecs[i].rd));
                chk($sformatf("v%0d_wb_data", i), 32'(o.data), 32'(vecs[i].data));
            end
            chk($sformatf("v%0d_illegal", i),     32'(o.ill),        32'(vecs[i].ill));
            chk($sformatf("v%0d_wb_alu_zero", i), 32'(o.wb_alu != 36'h0), 32'h0);
            chk($sformatf("v%0d_ready_3cyc", i),  32'(o.post_ready), 32'h1);
            chk($sformatf("v%0d_wb_pulse", i),    32'(o.post_wb),    32'h0);
            chk($sformatf("v%0d_ill_pulse", i),   32'(o.post_ill),   32'h0);
            chk($sformatf("v%0d_ovf", i),         32'(o.ovf),        32'(vecs[i].ovf));
        end

        // clear_ovf alone clears the flag
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("clear_ovf", 32'(ovf_flag), 32'h0);

        // A borrowing SUB in WB wins over a simultaneous clear_ovf
        clear_ovf = 1'b1;
        issue(enc(4'h2, 3'd4, 3'd1, 3'd2), o);
        clear_ovf = 1'b0;
        chk("prio_data", 32'(o.data), 32'h0000_FFFF);
        chk("prio_ovf",  32'(o.ovf),  32'h1);

        // instr_valid held high across four instructions
        idx = 0; xfers = 0; wbs = 0; xfer_prev = 1'b0;
        instr       = bb_ins[0];
        instr_valid = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            if (xfer_prev) begin
                idx++;
                if (idx < 4) instr = bb_ins[idx];
                else begin
                    instr_valid = 1'b0;
                    instr       = '0;
                end
            end
            chk($sformatf("bb_ready_k%0d", k), 32'(instr_ready), 32'((k % 3) == 0));
            chk($sformatf("bb_wb_k%0d", k),    32'(wb_valid),    32'(((k % 3) == 2) && (k <= 11)));
            if (wb_valid && wbs < 4) begin
                chk($sformatf("bb_data_%0d", wbs), 32'(wb_data), 32'(bb_exp[wbs]));
                wbs++;
            end
            xfer_prev = instr_ready && instr_valid;
            if (xfer_prev) xfers++;
        end
        instr_valid = 1'b0;
        chk("bb_transfers",  xfers, 32'd4);
        chk("bb_writebacks", wbs,   32'd4);

        // Reset during EXEC of ADD r7,r2,r2 abandons the instruction
        instr       = enc(4'h1, 3'd7, 3'd2, 3'd2);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("rx_exec_cop", 32'(alu_cop), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("rx_ready_low", 32'(instr_ready), 32'h0);
        chk("rx_wb_valid",  32'(wb_valid),    32'h0);
        chk("rx_alu_cop",   32'(alu_cop),     32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rx_idle_ready", 32'(instr_ready), 32'h1);
        chk("rx_no_wb",      32'(wb_valid),    32'h0);
        chk("rx_ovf",        32'(ovf_flag),    32'h0);
        issue(enc(4'h3, 3'd7, 3'd7, 3'd7), o);
        chk("rx_r7_wb",   32'(o.wb),   32'h1);
        chk("rx_r7_zero", 32'(o.data), 32'h0);
        issue(enc(4'h3, 3'd2, 3'd2, 3'd2), o);
        chk("rx_r2_zero", 32'(o.data), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the operand/result width; the instruction word is fixed at 16 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port instr, input, 16, the instruction: [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [8:0] imm9 (LDI only).
REQ-005 SHALL have ports instr_valid (input, 1) and instr_ready (output, 1), the instruction handshake.
REQ-006 SHALL have ports alu_reg_A and alu_reg_B (output, DATA_WIDTH), the ALU operands, and alu_cop (output, 4), the ALU operation code.
REQ-007 SHALL have ports alu_result (input, DATA_WIDTH) and alu_ovf (input, 1), the combinational ALU response.
REQ-008 SHALL have ports wb_valid (output, 1), wb_rd (output, 3) and wb_data (output, DATA_WIDTH), the write-back notification.
REQ-009 SHALL have ports ovf_flag (output, 1), clear_ovf (input, 1) and illegal (output, 1).

Function
REQ-010 SHALL contain an 8 x DATA_WIDTH register file r0..r7, all writable, read only by this block.
REQ-011 SHALL decode opcodes to ALU cop: 0x0 CLR->0000, 0x1 ADD->0001, 0x2 SUB->0010, 0x3 MOV->0011 (rd<=rb), 0x4 CMPEQ->0100.
REQ-012 SHALL treat opcode 0x7 LDI as rd <= zero-extended imm9 with no ALU use, cop driven 0000.
REQ-013 SHALL treat every other opcode as illegal: no register write, no wb_valid, illegal pulses high for one cycle in WB.
REQ-014 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE, one state per cycle, with no other transitions except reset.
REQ-015 SHALL assert instr_ready only in IDLE; the transfer occurs when instr_valid and instr_ready are both high, latching instr and moving to EXEC.
REQ-016 SHALL, in IDLE with no transfer, remain in IDLE.
REQ-017 SHALL, in EXEC, drive alu_reg_A=r[ra], alu_reg_B=r[rb] and alu_cop=decoded cop from registered values, and register alu_result/alu_ovf at end of EXEC.
REQ-018 SHALL, in WB, write the captured result to r[rd], pulse wb_valid for one cycle with wb_rd/wb_data equal to the written values.
REQ-019 SHALL drive alu_reg_A, alu_reg_B and alu_cop to 0 outside EXEC.
REQ-020 SHALL read operands as of EXEC, so an instruction with ra or rb equal to the prior instruction's rd sees the written value.
REQ-021 SHALL yield a throughput of one instruction per 3 cycles and a latency of 2 cycles from the transfer to wb_valid.
REQ-022 SHALL update ovf_flag from captured alu_ovf in WB for ADD/SUB only; CLR, MOV, CMPEQ, LDI and illegal opcodes SHALL leave it unchanged.
REQ-023 SHALL clear ovf_flag on clear_ovf; a simultaneous WB setting the flag SHALL take priority over clear_ovf.

Reset
REQ-024 SHALL, on reset high at a clock edge, enter IDLE, zero r0..r7 and deassert wb_valid, illegal and ovf_flag.
REQ-025 SHALL, on reset, zero wb_rd, wb_data, alu_reg_A, alu_reg_B and alu_cop.
REQ-026 SHALL, on reset in EXEC or WB, abandon the in-flight instruction with no register write and no wb_valid.
REQ-027 SHALL hold instr_ready low during the reset cycle.

Configuration
REQ-028 SHALL, with macro ALU_ISSUE_STICKY_OVF_EN defined, make ovf_flag sticky: it is set by ADD/SUB overflow and cleared only by clear_ovf or reset.
REQ-029 SHALL, without ALU_ISSUE_STICKY_OVF_EN, load ovf_flag with the overflow of the latest ADD/SUB in WB; clear_ovf still clears it.

Verification
REQ-030 SHALL cover LDI r1,0x0FF; LDI r2,0x001; ADD r3,r1,r2 -> wb_data 0x0100 for rd=3, ovf_flag 0.
REQ-031 SHALL cover r1=0x0000, r2=0x0001; SUB r4,r1,r2 -> r4=0xFFFF and ovf_flag 1; then ADD r5,r2,r2 -> ovf_flag stays 1 with the macro and becomes 0 without it.
REQ-032 SHALL cover CMPEQ r6,r1,r1 -> wb_data 0x0001; CMPEQ r6,r1,r2 with unequal values -> wb_data 0x0000.
REQ-033 SHALL cover opcode 0xA -> illegal pulse one cycle, no wb_valid, all registers unchanged, instr_ready back high 3 cycles after the transfer.
REQ-034 SHALL cover instr_valid held high continuously for 4 instructions -> exactly 4 transfers, instr_ready high only every third cycle, and wb_valid 2 cycles after each transfer.
REQ-035 SHALL cover reset asserted in EXEC of ADD r7 -> no wb_valid, r7 reads 0 afterward, FSM in IDLE.
